lemon_fetch_pc: RTL

- Parametrised program-counter and fetch sequencer for the LemonPC core.
- Replaces the free-running pc+4 counter with a reset vector, a one-outstanding-request fetch handshake to instruction memory, branch/trap redirects, stall and halt.
- Sits between the execute stage, which supplies redirects, and the instruction memory port. Delivers each (pc, inst) pair downstream as a one-cycle pulse.

---
 rtl/lemon_fetch_pc.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lemon_fetch_pc.sv
// lemon_fetch_pc: program counter and one-outstanding-request fetch sequencer for LemonPC.
// Define LEMON_FETCH_RVC_EN for compressed-instruction (+2) sequencing and 2-byte alignment.
module lemon_fetch_pc #(
    parameter int          XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h8000_0000,
    parameter int          ILEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_addr,
    input  logic            fetch_ready,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_inst,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            misalign,
    output logic            halted
);

    localparam logic [1:0] StBoot = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StHalt = 2'd3;

    localparam logic [XLEN-1:0] ResetPc = RESET_VECTOR[XLEN-1:0];

    logic [1:0]      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] dpc_q;
    logic [ILEN-1:0] inst_q;
    logic            inst_valid_q;
    logic            misalign_q;
    logic            kill_q;
    logic            halt_q;

    logic            halt_eff;
    logic            handshake;
    logic            target_ok;
    logic            redir_take;
    logic            misalign_d;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] seq_inc;

`ifdef LEMON_FETCH_RVC_EN
    assign target_ok = ~redirect_target[0];
    assign trap_pc   = trap_vector & ~XLEN'(1);
    assign seq_inc   = (resp_inst[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4);
`else
    assign target_ok = (redirect_target[1:0] == 2'b00);
    assign trap_pc   = trap_vector & ~XLEN'(3);
    assign seq_inc   = XLEN'(4);
`endif

    // Halt is sticky: once seen it is honoured at the next safe point.
    assign halt_eff    = halt | halt_q;
    assign fetch_valid = (state_q == StReq) && !stall && !halt_eff;
    assign handshake   = fetch_valid && fetch_ready;

    // Trap beats redirect; a misaligned redirect is dropped and flagged.
    assign redir_take = trap_valid | (redirect_valid & target_ok);
    assign redir_pc   = trap_valid ? trap_pc : redirect_target;
    assign misalign_d = ~trap_valid & redirect_valid & ~target_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBoot;
            pc_q         <= ResetPc;
            dpc_q        <= ResetPc;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            kill_q       <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            inst_valid_q <= 1'b0;
            misalign_q   <= misalign_d && (state_q != StHalt);
            if (halt) begin
                halt_q <= 1'b1;
            end
            case (state_q)
                StBoot: begin
                    if (redir_take) begin
                        pc_q <= redir_pc;
                    end
                    state_q <= StReq;
                end
                StReq: begin
                    if (redir_take) begin
                        pc_q <= redir_pc;
                    end
                    if (handshake) begin
                        state_q <= StResp;
                        // Redirect racing the accept: the response in flight is stale.
                        kill_q  <= redir_take;
                    end else if (halt_eff) begin
                        state_q <= StHalt;
                    end
                end
                StResp: begin
                    if (resp_valid) begin
                        if (!kill_q) begin
                            inst_valid_q <= 1'b1;
                            inst_q       <= resp_inst;
                            dpc_q        <= pc_q;
                            pc_q         <= redir_take ? redir_pc : pc_q + seq_inc;
                        end else if (redir_take) begin
                            pc_q <= redir_pc;
                        end
                        kill_q  <= 1'b0;
                        state_q <= halt_eff ? StHalt : StReq;
                    end else if (redir_take) begin
                        pc_q   <= redir_pc;
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fetch_addr = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign pc         = inst_valid_q ? dpc_q : pc_q;
    assign misalign   = misalign_q;
    assign halted     = (state_q == StHalt);

endmodule
